led_bounce_monitor: RTL and testbench
=====================================

// Module: led_bounce_monitor
// PURPOSE
//   Receive-side checker for the bouncing one-hot LED pattern driven by the LED-mode
//   generators. Samples a WIDTH-bit LED bus on each enable strobe and decodes it into
//   position and direction. Verifies each sample against the expected bounce sequence
//   and flags lock and errors. Sits beside the LED mode mux for self-test and debug.
// PARAMETERS
//   WIDTH       8   LED bus width; must be >= 3
//   LOCK_COUNT  4   consecutive correct transitions in TRACK before locked=1 (1..15)
//   CNT_W       8   error counter width
// PORTS
//   clk      in   1                 rising-edge clock
//   reset    in   1                 synchronous, active-high reset
//   en       in   1                 sample strobe; pulse the cycle after the generator updates
//   led_in   in   WIDTH             observed LED bus
//   pos      out  $clog2(WIDTH)     index of the lit bit in the last accepted sample
//   dir      out  1                 expected next move: 1 = toward bit WIDTH-1, 0 = toward bit 0
//   locked   out  1                 pattern tracked and verified
//   err      out  1                 one-cycle pulse per sequence error
//   err_cnt  out  CNT_W             saturating error count (see CONFIGURATION)
// BEHAVIOUR
//   - Timing: one clock, synchronous active-high reset. All outputs are registered.
//     Latency is 1: led_in is captured on an edge with en=1, and the outputs reflect it
//     after that edge.
//   - Reset: state=ACQ, pos=0, dir=1, locked=0, err=0, err_cnt=0, good_cnt=0.
//     Reset overrides en and any in-flight operation.
//   - en=0: every register holds, except err, which returns to 0.
//   - Valid sample: exactly one bit of led_in set. Zero bits or two or more bits is invalid.
//   - Expected next position: pos+1 if dir=1, else pos-1.
//   - Direction at the ends: after accepting pos=WIDTH-1, dir=0. After accepting pos=0, dir=1.
//     Otherwise dir is unchanged.
//   - States:
//     ACQ:   invalid -> stay in ACQ.
//            valid at an end (bit 0 or bit WIDTH-1) -> pos=idx, dir set by the end rule,
//            good_cnt=0, go to TRACK.
//            valid elsewhere -> pos=idx, go to DIR.
//     DIR:   valid and |idx-pos|==1 -> dir=(idx>pos), then apply the end rule, pos=idx,
//            good_cnt=1, go to TRACK.
//            valid but not adjacent -> pos=idx, stay in DIR.
//            invalid -> go to ACQ.
//            No err is raised in ACQ or DIR.
//     TRACK: idx==expected -> pos and dir update, good_cnt increments and saturates at
//            LOCK_COUNT.
//            mismatch -> err=1 for one cycle, good_cnt=0, locked=0; then valid -> pos=idx,
//            go to DIR; invalid -> pos holds, go to ACQ.
//   - locked = (state==TRACK && good_cnt>=LOCK_COUNT). It is registered, so it updates on
//     the same edge as pos.
//   - Back-to-back en strobes on consecutive cycles are legal; each one is evaluated.
// CONFIGURATION
//   LED_MON_ERRCNT_EN defined:
//     - err_cnt increments on every err pulse and saturates at 2**CNT_W-1.
//     - reset clears it; it is not cleared by loss of lock.
//   LED_MON_ERRCNT_EN undefined:
//     - no counter flops; err_cnt is tied to 0.
//     - the port is kept so the interface is stable.
// TESTING
//   1 Reset, then en samples 01,02,04,08,10 -> pos 0,1,2,3,4; dir=1 throughout;
//     locked=1 after the 0x10 sample; err never asserted.
//   2 While locked: samples 20,40,80,40,20 -> pos 5,6,7,6,5; dir=0 from the 0x80 sample
//     onward; locked stays 1.
//   3 Locked at pos 3, dir 1: sample 0x20 -> err pulses 1 cycle, locked=0, err_cnt=1,
//     pos=5, state DIR; then sample 0x40 -> TRACK, dir=1.
//   4 Locked: sample 0x00, then 0x18 -> err on 0x00, pos holds, state ACQ; 0x18 gives no
//     err; err_cnt=1 with the macro, 0 without.
//   5 Locked; en=0 for 10 cycles while led_in toggles randomly -> all outputs hold, err=0.
//     Then assert reset mid-TRACK -> next cycle pos=0, dir=1, locked=0, err_cnt=0.
//   6 Macro on, CNT_W=8: force 300 mismatches -> err_cnt saturates at 255.
//     Macro off: err_cnt=0 throughout.

Source files
------------

// File: rtl/led_bounce_monitor.sv
// led_bounce_monitor: decodes and verifies a bouncing one-hot LED bus; LED_MON_ERRCNT_EN adds a saturating error counter
module led_bounce_monitor #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [WIDTH-1:0]         led_in,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     dir,
  output logic                     locked,
  output logic                     err,
  output logic [CNT_W-1:0]         err_cnt
);
  localparam int PW = $clog2(WIDTH);
  typedef enum logic [1:0] {ACQ, DIR, TRACK} state_t;
  state_t        r_state;
  logic [PW-1:0] r_pos;
  logic          r_dir, r_locked, r_err;
  logic [3:0]    r_good;
  logic [PW-1:0] w_idx, w_exp;
  logic          w_valid, w_adj, w_atend, w_match;
  logic [3:0]    w_good_n;
  function automatic logic end_dir(input logic [PW-1:0] p, input logic d);
    return p == PW'(WIDTH-1) ? 1'b0 : p == '0 ? 1'b1 : d;
  endfunction
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (led_in[i]) w_idx = PW'(i);
  end
  assign w_valid  = led_in != '0 && (led_in & (led_in - WIDTH'(1))) == '0;
  assign w_exp    = r_dir ? r_pos + PW'(1) : r_pos - PW'(1);
  assign w_adj    = {1'b0, w_idx} == {1'b0, r_pos} + (PW+1)'(1) || {1'b0, r_pos} == {1'b0, w_idx} + (PW+1)'(1);
  assign w_atend  = w_idx == '0 || w_idx == PW'(WIDTH-1);
  assign w_match  = w_valid && w_idx == w_exp;
  assign w_good_n = r_good >= 4'(LOCK_COUNT) ? 4'(LOCK_COUNT) : r_good + 4'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ACQ;
      r_pos    <= '0;
      r_dir    <= 1'b1;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_good   <= '0;
    end else begin
      r_err <= 1'b0;
      if (en) begin
        case (r_state)
          ACQ: if (w_valid) begin
            r_pos <= w_idx;
            if (w_atend) begin
              r_dir   <= end_dir(w_idx, r_dir);
              r_good  <= '0;
              r_state <= TRACK;
            end else r_state <= DIR;
          end
          DIR: if (!w_valid) r_state <= ACQ;
          else begin
            r_pos <= w_idx;
            if (w_adj) begin
              r_dir    <= end_dir(w_idx, w_idx > r_pos);
              r_good   <= 4'd1;
              r_state  <= TRACK;
              r_locked <= LOCK_COUNT <= 1;
            end
          end
          default: if (w_match) begin
            r_pos    <= w_idx;
            r_dir    <= end_dir(w_idx, r_dir);
            r_good   <= w_good_n;
            r_locked <= w_good_n >= 4'(LOCK_COUNT);
          end else begin
            r_err    <= 1'b1;
            r_good   <= '0;
            r_locked <= 1'b0;
            r_state  <= w_valid ? DIR : ACQ;
            if (w_valid) r_pos <= w_idx;
          end
        endcase
      end
    end
  end
  assign pos    = r_pos;
  assign dir    = r_dir;
  assign locked = r_locked;
  assign err    = r_err;
`ifdef LED_MON_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_err_cnt <= '0;
    else if (en && r_state == TRACK && !w_match && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_W'(1);
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_led_bounce_monitor.sv
// tb_led_bounce_monitor: table vectors, corner sequences and randomized checks against a behavioural model
module tb_led_bounce_monitor;
  localparam int W = 8;
  localparam int LC = 4;
  localparam int CW = 8;
  logic clk = 0, reset = 1, en = 0;
  logic [W-1:0] led_in = '0;
  logic [2:0] pos;
  logic dir, locked, err;
  logic [CW-1:0] err_cnt;
  int tests = 0, fails = 0;
  led_bounce_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .led_in(led_in),
    .pos(pos), .dir(dir), .locked(locked), .err(err), .err_cnt(err_cnt));
  always #5 clk = ~clk;
  int  m_mode;
  int  m_pos, m_good, m_cnt;
  bit  m_dir, m_err;
`ifdef LED_MON_ERRCNT_EN
  localparam bit CNT_ON = 1;
`else
  localparam bit CNT_ON = 0;
`endif
  function automatic bit bounce(input int p, input bit d);
    if (p == W-1) return 0;
    if (p == 0) return 1;
    return d;
  endfunction
  function automatic bit m_locked();
    return m_mode == 2 && m_good >= LC;
  endfunction
  task automatic model(input bit rst, input bit e, input logic [W-1:0] v);
    int idx;
    bit ok;
    m_err = 0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_dir = 1; m_good = 0; m_cnt = 0;
      return;
    end
    if (!e) return;
    ok = $countones(v) == 1;
    idx = ok ? $clog2(v) : -1;
    if (m_mode == 0) begin
      if (ok) begin
        m_pos = idx;
        if (idx == 0 || idx == W-1) begin m_dir = bounce(idx, m_dir); m_good = 0; m_mode = 2; end
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (!ok) m_mode = 0;
      else if (idx - m_pos == 1 || m_pos - idx == 1) begin
        m_dir = bounce(idx, idx > m_pos); m_pos = idx; m_good = 1; m_mode = 2;
      end else m_pos = idx;
    end else begin
      if (ok && idx == m_pos + (m_dir ? 1 : -1)) begin
        m_pos = idx; m_dir = bounce(idx, m_dir);
        m_good = m_good + 1 > LC ? LC : m_good + 1;
      end else begin
        m_err = 1; m_good = 0;
        if (CNT_ON && m_cnt < (1 << CW) - 1) m_cnt++;
        if (ok) begin m_pos = idx; m_mode = 1; end else m_mode = 0;
      end
    end
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic chk_model(input string tag);
    chk({tag, ".pos"}, pos, m_pos);
    chk({tag, ".dir"}, dir, m_dir);
    chk({tag, ".locked"}, locked, m_locked());
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".err_cnt"}, err_cnt, m_cnt);
  endtask
  task automatic step(input bit e, input logic [W-1:0] v);
    en = e; led_in = v;
    @(posedge clk); #1;
    model(0, e, v);
  endtask
  task automatic do_reset();
    reset = 1; en = 0;
    @(posedge clk); #1;
    reset = 0;
    model(1, 0, '0);
  endtask
  typedef struct {bit e; logic [W-1:0] led; int p; bit d, l, er;} vec_t;
  vec_t vt[$];
  logic [2:0] h_pos;
  bit h_dir, h_lock;
  logic [CW-1:0] h_cnt;
  initial begin
    vt = '{
      '{1, 8'h01, 0, 1, 0, 0}, '{1, 8'h02, 1, 1, 0, 0}, '{1, 8'h04, 2, 1, 0, 0},
      '{1, 8'h08, 3, 1, 0, 0}, '{1, 8'h10, 4, 1, 1, 0},
      '{1, 8'h20, 5, 1, 1, 0}, '{1, 8'h40, 6, 1, 1, 0}, '{1, 8'h80, 7, 0, 1, 0},
      '{1, 8'h40, 6, 0, 1, 0}, '{1, 8'h20, 5, 0, 1, 0},
      '{1, 8'h10, 4, 0, 1, 0}, '{1, 8'h08, 3, 0, 1, 0}, '{1, 8'h04, 2, 0, 1, 0},
      '{1, 8'h02, 1, 0, 1, 0}, '{1, 8'h01, 0, 1, 1, 0}, '{1, 8'h02, 1, 1, 1, 0},
      '{1, 8'h04, 2, 1, 1, 0}, '{1, 8'h08, 3, 1, 1, 0},
      '{1, 8'h20, 5, 1, 0, 1}, '{1, 8'h40, 6, 1, 0, 0},
      '{1, 8'h80, 7, 0, 0, 0}, '{1, 8'h40, 6, 0, 0, 0}, '{1, 8'h20, 5, 0, 1, 0},
      '{0, 8'hFF, 5, 0, 1, 0},
      '{1, 8'h00, 5, 0, 0, 1}, '{1, 8'h18, 5, 0, 0, 0},
      '{1, 8'h08, 3, 0, 0, 0}, '{1, 8'h04, 2, 0, 0, 0}, '{1, 8'h02, 1, 0, 0, 0}
    };
    do_reset();
    chk("rst.pos", pos, 0);
    chk("rst.dir", dir, 1);
    chk("rst.locked", locked, 0);
    chk("rst.err", err, 0);
    chk("rst.err_cnt", err_cnt, 0);
    foreach (vt[k]) begin
      step(vt[k].e, vt[k].led);
      chk($sformatf("vec%0d.pos", k), pos, vt[k].p);
      chk($sformatf("vec%0d.dir", k), dir, vt[k].d);
      chk($sformatf("vec%0d.locked", k), locked, vt[k].l);
      chk($sformatf("vec%0d.err", k), err, vt[k].er);
      chk($sformatf("vec%0d.err_cnt", k), err_cnt, m_cnt);
    end
    chk("vec.err_cnt_final", err_cnt, CNT_ON ? 2 : 0);
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 8'(1 << k));
    chk("relock.locked", locked, 1);
    h_pos = pos; h_dir = dir; h_lock = locked; h_cnt = err_cnt;
    for (int k = 0; k < 10; k++) begin
      step(0, 8'($urandom));
      chk("hold.pos", pos, h_pos);
      chk("hold.dir", dir, h_dir);
      chk("hold.locked", locked, h_lock);
      chk("hold.err", err, 0);
      chk("hold.err_cnt", err_cnt, h_cnt);
    end
    step(1, 8'h00);
    chk("pre_rst.err", err, 1);
    step(1, 8'h01);
    reset = 1; en = 1; led_in = 8'h02;
    @(posedge clk); #1;
    reset = 0; model(1, 0, '0);
    chk("midrst.pos", pos, 0);
    chk("midrst.dir", dir, 1);
    chk("midrst.locked", locked, 0);
    chk("midrst.err_cnt", err_cnt, 0);
    for (int k = 0; k < 300; k++) begin
      step(1, 8'h01);
      step(1, 8'h00);
      chk_model("sat");
    end
    chk("sat.err_cnt", err_cnt, CNT_ON ? 255 : 0);
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int nx;
      logic [W-1:0] v;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        chk_model("rnd_rst");
        continue;
      end
      nx = m_pos + (m_dir ? 1 : -1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: v = (nx >= 0 && nx < W) ? 8'(1 << nx) : 8'h01;
        6, 7:             v = 8'(1 << $urandom_range(0, W-1));
        8:                v = 8'h00;
        default:          v = 8'($urandom);
      endcase
      step($urandom_range(0, 5) != 0, v);
      chk_model("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
